// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx byte serializer between N requesters, locked per message.
// Latency: 1 cycle request-to-grant, 0 added cycles per in-message byte, min 1 idle cycle between messages.
// Backpressure: tx_ready passes straight to the owner's req_ready; non-owners see ready=0 and must hold.
// Optional idle-owner forced unlock is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*8-1:0] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout
);

  localparam int OW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, owner_nxt;
  logic [OW-1:0] last_owner, last_owner_nxt;
  logic [OW-1:0] pick;
  logic [N-1:0]  grant_nxt;
  logic [N-1:0]  rot;
  logic          found;
  logic [7:0]    own_data;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          release_last;
  logic          force_unlock;

  // Index base+off wrapped into 0..N-1; off never exceeds N, so one subtraction suffices.
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return OW'(s);
  endfunction

  // Rotate requests so bit 0 is the requester just after last_owner, then take the first set bit.
  always_comb begin
    rot   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req_valid[wrap_add(last_owner, k + 1)];
    end
    for (int k = 0; k < N; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        pick  = wrap_add(last_owner, k + 1);
      end
    end
  end

  assign own_data     = req_data[{owner, 3'b000} +: 8];
  assign own_valid    = req_valid[owner];
  assign own_last     = req_last[owner];
  assign xfer         = (state == OWN) && own_valid && tx_ready;
  assign release_last = xfer && own_last;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  // A last-byte transfer on the terminal-count cycle wins: it is a normal release, not a timeout.
  assign force_unlock = (state == OWN) && (idle_cnt == CW'(TIMEOUT)) && !release_last;

  // Count consecutive owner cycles with no valid byte; any valid cycle or a new lock restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != OWN) || force_unlock || own_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign force_unlock   = 1'b0;
`endif

  assign timeout = force_unlock;
  assign busy    = (state == OWN);

  // Next-state and pass-through: only the owner's byte reaches the UART, and only while locked.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    grant_nxt      = grant;
    req_ready      = '0;
    tx_data        = '0;
    tx_valid       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = OWN;
          owner_nxt       = pick;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
        end
      end
      OWN: begin
        tx_data          = own_data;
        tx_valid         = own_valid;
        req_ready[owner] = tx_ready;
        if (release_last || force_unlock) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          grant_nxt      = '0;
        end
      end
    endcase
  end

  // State registers; last_owner resets to N-1 so requester 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N - 1);
      grant      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      grant      <= grant_nxt;
    end
  end

endmodule
